// File: rtl/bas_search_ctrl.sv
// bas_search_ctrl: iteration controller for fixed-point Beetle Antennae Search.
// Seeds the direction LFSR, samples one direction per iteration, presents the
// left/right antenna candidates to an external evaluator and steps the beetle
// toward the lower-fitness antenna with a step that shrinks as iterations pass.
// Optional feature macro: BAS_BEST_TRACK_EN (track best candidate and fitness).
module bas_search_ctrl #(
  parameter int unsigned N_ITER      = 64,
  parameter int unsigned D_SHIFT     = 2,
  parameter int unsigned STEP_SHIFT0 = 1,
  parameter int unsigned DECAY_LOG2  = 3
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic signed [15:0] init_x_i,
  input  logic signed [15:0] init_y_i,
  input  logic [8:0]         seed_x_i,
  input  logic [8:0]         seed_y_i,
  output logic               lfsr_load_o,
  output logic [8:0]         lfsr_seed_x_o,
  output logic [8:0]         lfsr_seed_y_o,
  input  logic [8:0]         dir_x_i,
  input  logic [8:0]         dir_y_i,
  output logic signed [15:0] cand_x_o,
  output logic signed [15:0] cand_y_o,
  output logic               cand_valid_o,
  output logic               cand_side_o,
  input  logic               fit_valid_i,
  input  logic signed [15:0] fit_value_i,
  output logic signed [15:0] pos_x_o,
  output logic signed [15:0] pos_y_o,
  output logic [15:0]        iter_o,
  output logic               busy_o,
  output logic               done_o,
  output logic signed [15:0] best_x_o,
  output logic signed [15:0] best_y_o,
  output logic signed [15:0] best_fit_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_SEED, S_SAMPLE, S_EVAL_L, S_EVAL_R, S_UPDATE, S_DONE
  } state_e;

  state_e             state_q;
  logic signed [15:0] pos_x_q, pos_y_q;
  logic [15:0]        iter_q;
  logic [8:0]         seed_x_q, seed_y_q;
  logic [8:0]         dir_x_q, dir_y_q;
  logic signed [15:0] cand_x_q, cand_y_q;
  logic               cand_valid_q, cand_side_q;
  logic signed [15:0] f_l_q, f_r_q;
  logic               lfsr_load_q, busy_q, done_q;

  logic signed [15:0] samp_ext_x, samp_ext_y;
  logic signed [15:0] dir_ext_x, dir_ext_y;
  logic signed [15:0] step_x, step_y;
  logic [16:0]        sh_sum;
  logic [3:0]         sh;
  logic signed [15:0] cand_l_x_d, cand_l_y_d, cand_r_x_d, cand_r_y_d;
  logic signed [15:0] pos_x_d, pos_y_d;
  logic [15:0]        iter_d;
  logic               fit_accept;

  // Clamp a 17-bit signed result into the 16-bit range.
  function automatic logic signed [15:0] sat16(input logic signed [16:0] s);
    if (s[16] != s[15]) return s[16] ? 16'sh8000 : 16'sh7FFF;
    return s[15:0];
  endfunction

  function automatic logic signed [15:0] sat_add(input logic signed [15:0] a,
                                                 input logic signed [15:0] b);
    logic signed [16:0] s;
    s = 17'(a) + 17'(b);
    return sat16(s);
  endfunction

  function automatic logic signed [15:0] sat_sub(input logic signed [15:0] a,
                                                 input logic signed [15:0] b);
    logic signed [16:0] s;
    s = 17'(a) - 17'(b);
    return sat16(s);
  endfunction

  // Offsets, decaying step and the saturated candidate / next positions.
  always_comb begin
    // Left candidate is formed from the live LFSR value as it is being sampled.
    samp_ext_x = {{7{dir_x_i[8]}}, dir_x_i};
    samp_ext_y = {{7{dir_y_i[8]}}, dir_y_i};
    dir_ext_x  = {{7{dir_x_q[8]}}, dir_x_q};
    dir_ext_y  = {{7{dir_y_q[8]}}, dir_y_q};
    sh_sum     = 17'(STEP_SHIFT0) + 17'(iter_q >> DECAY_LOG2);
    sh         = (sh_sum > 17'd15) ? 4'd15 : sh_sum[3:0];
    step_x     = dir_ext_x >>> sh;
    step_y     = dir_ext_y >>> sh;
    cand_l_x_d = sat_add(pos_x_q, samp_ext_x >>> D_SHIFT);
    cand_l_y_d = sat_add(pos_y_q, samp_ext_y >>> D_SHIFT);
    cand_r_x_d = sat_sub(pos_x_q, dir_ext_x >>> D_SHIFT);
    cand_r_y_d = sat_sub(pos_y_q, dir_ext_y >>> D_SHIFT);
    pos_x_d    = pos_x_q;
    pos_y_d    = pos_y_q;
    if (f_l_q < f_r_q) begin
      pos_x_d = sat_add(pos_x_q, step_x);
      pos_y_d = sat_add(pos_y_q, step_y);
    end else if (f_l_q > f_r_q) begin
      pos_x_d = sat_sub(pos_x_q, step_x);
      pos_y_d = sat_sub(pos_y_q, step_y);
    end
    iter_d     = iter_q + 16'd1;
    fit_accept = cand_valid_q && fit_valid_i &&
                 ((state_q == S_EVAL_L) || (state_q == S_EVAL_R));
  end

  // Main search FSM with all outputs registered.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      pos_x_q      <= '0;
      pos_y_q      <= '0;
      iter_q       <= '0;
      seed_x_q     <= '0;
      seed_y_q     <= '0;
      dir_x_q      <= '0;
      dir_y_q      <= '0;
      cand_x_q     <= '0;
      cand_y_q     <= '0;
      cand_valid_q <= 1'b0;
      cand_side_q  <= 1'b0;
      f_l_q        <= '0;
      f_r_q        <= '0;
      lfsr_load_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      lfsr_load_q <= 1'b0;
      done_q      <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            pos_x_q     <= init_x_i;
            pos_y_q     <= init_y_i;
            seed_x_q    <= seed_x_i;
            seed_y_q    <= seed_y_i;
            iter_q      <= '0;
            busy_q      <= 1'b1;
            lfsr_load_q <= 1'b1;
            state_q     <= S_SEED;
          end
        end
        S_SEED: state_q <= S_SAMPLE;
        S_SAMPLE: begin
          dir_x_q      <= dir_x_i;
          dir_y_q      <= dir_y_i;
          cand_x_q     <= cand_l_x_d;
          cand_y_q     <= cand_l_y_d;
          cand_side_q  <= 1'b0;
          cand_valid_q <= 1'b1;
          state_q      <= S_EVAL_L;
        end
        S_EVAL_L: begin
          if (fit_valid_i) begin
            f_l_q       <= fit_value_i;
            cand_x_q    <= cand_r_x_d;
            cand_y_q    <= cand_r_y_d;
            cand_side_q <= 1'b1;
            state_q     <= S_EVAL_R;
          end
        end
        S_EVAL_R: begin
          if (fit_valid_i) begin
            f_r_q        <= fit_value_i;
            cand_valid_q <= 1'b0;
            state_q      <= S_UPDATE;
          end
        end
        S_UPDATE: begin
          pos_x_q <= pos_x_d;
          pos_y_q <= pos_y_d;
          iter_q  <= iter_d;
          if (iter_d == 16'(N_ITER)) begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            state_q <= S_SAMPLE;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef BAS_BEST_TRACK_EN
  logic signed [15:0] best_x_q, best_y_q, best_fit_q;

  // Strict-improvement tracker: ties keep the earlier candidate.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      best_x_q   <= '0;
      best_y_q   <= '0;
      best_fit_q <= '0;
    end else if ((state_q == S_IDLE) && start_i) begin
      best_fit_q <= 16'sh7FFF;
    end else if (fit_accept && (fit_value_i < best_fit_q)) begin
      best_fit_q <= fit_value_i;
      best_x_q   <= cand_x_q;
      best_y_q   <= cand_y_q;
    end
  end

  assign best_x_o   = best_x_q;
  assign best_y_o   = best_y_q;
  assign best_fit_o = best_fit_q;
`else
  logic started_q;

  // Only remembers that a run has been started; best_* just mirror pos.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                          started_q <= 1'b0;
    else if ((state_q == S_IDLE) && start_i) started_q <= 1'b1;
  end

  assign best_x_o   = pos_x_q;
  assign best_y_o   = pos_y_q;
  assign best_fit_o = started_q ? 16'sh7FFF : 16'sh0000;
`endif

  assign lfsr_load_o   = lfsr_load_q;
  assign lfsr_seed_x_o = seed_x_q;
  assign lfsr_seed_y_o = seed_y_q;
  assign cand_x_o      = cand_x_q;
  assign cand_y_o      = cand_y_q;
  assign cand_valid_o  = cand_valid_q;
  assign cand_side_o   = cand_side_q;
  assign pos_x_o       = pos_x_q;
  assign pos_y_o       = pos_y_q;
  assign iter_o        = iter_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;

endmodule

// File: tb/tb_bas_search_ctrl.sv
// Self-checking bench for bas_search_ctrl: acts as LFSR and fitness evaluator,
// predicts candidates/positions with a behavioural model into a scoreboard.
module tb_bas_search_ctrl;
  localparam int N_IT = 64;
  localparam int DSH  = 2;
  localparam int S0   = 1;
  localparam int DL   = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [15:0] init_x = '0, init_y = '0;
  logic [8:0]  seed_x = '0, seed_y = '0;
  logic        lfsr_load;
  logic [8:0]  lfsr_seed_x, lfsr_seed_y;
  logic [15:0] cand_x, cand_y;
  logic        cand_valid, cand_side;
  logic        fit_valid = 1'b0;
  logic [15:0] fit_value = '0;
  logic [15:0] pos_x, pos_y, iter;
  logic        busy, done;
  logic [15:0] best_x, best_y, best_fit;

  logic [8:0]  lx = '0, ly = '0;
  logic [8:0]  samp_x = '0, samp_y = '0;
  int          cyc = 0;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string       tag;
    logic [15:0] x;
    logic [15:0] y;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  bas_search_ctrl #(.N_ITER(N_IT), .D_SHIFT(DSH), .STEP_SHIFT0(S0), .DECAY_LOG2(DL)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start),
    .init_x_i(init_x), .init_y_i(init_y), .seed_x_i(seed_x), .seed_y_i(seed_y),
    .lfsr_load_o(lfsr_load), .lfsr_seed_x_o(lfsr_seed_x), .lfsr_seed_y_o(lfsr_seed_y),
    .dir_x_i(lx), .dir_y_i(ly),
    .cand_x_o(cand_x), .cand_y_o(cand_y), .cand_valid_o(cand_valid), .cand_side_o(cand_side),
    .fit_valid_i(fit_valid), .fit_value_i(fit_value),
    .pos_x_o(pos_x), .pos_y_o(pos_y), .iter_o(iter), .busy_o(busy), .done_o(done),
    .best_x_o(best_x), .best_y_o(best_y), .best_fit_o(best_fit)
  );

  // 9-bit LFSR (x^9 + x^5 + 1); samp_* holds the value seen at the last edge.
  always @(posedge clk) begin
    cyc    <= cyc + 1;
    samp_x <= lx;
    samp_y <= ly;
    if (lfsr_load) begin
      lx <= lfsr_seed_x;
      ly <= lfsr_seed_y;
    end else begin
      lx <= {lx[7:0], lx[8] ^ lx[4]};
      ly <= {ly[7:0], ly[8] ^ ly[4]};
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic int s16(input logic [15:0] v);
    return int'($signed(v));
  endfunction

  function automatic int ext9(input logic [8:0] d);
    return d[8] ? int'(d) - 512 : int'(d);
  endfunction

  task automatic chk_zero(input string tag);
    check_val({tag, "_load"}, lfsr_load, 0);
    check_val({tag, "_seeds"}, {lfsr_seed_x, lfsr_seed_y}, 0);
    check_val({tag, "_cand"}, {cand_x, cand_y}, 0);
    check_val({tag, "_cflags"}, {cand_valid, cand_side}, 0);
    check_val({tag, "_pos"}, {pos_x, pos_y}, 0);
    check_val({tag, "_iter"}, iter, 0);
    check_val({tag, "_busy_done"}, {busy, done}, 0);
    check_val({tag, "_best"}, {best_x, best_y}, 0);
    check_val({tag, "_bestfit"}, best_fit, 0);
  endtask

  // Wait (bounded) until the DUT presents the candidate for the given side.
  task automatic wait_cand(input logic side, output bit ok);
    int cnt = 0;
    ok = 1'b1;
    while (!(cand_valid === 1'b1 && cand_side === side)) begin
      @(negedge clk);
      cnt++;
      if (cnt > 20) begin
        check_val("cand_timeout", cnt, 0);
        ok = 1'b0;
        return;
      end
    end
  endtask

  // One full run. fmode: 0=(5,10) 1=(7,7) 2=random 3=(0,0) 4=(10,5).
  task automatic run(input logic [15:0] ix, input logic [15:0] iy,
                     input logic [8:0] sx, input logic [8:0] sy,
                     input int fmode, input int waitc, input int abort_it, input int pulse_it);
    int px, py, npx, npy, bfit, bx, by, c0, dx, dy, ox, oy, sh, fl, fr;
    logic [15:0] cxl, cyl, cxr, cyr;
    exp_t e;
    bit ok;
    sb.delete();
    @(negedge clk);
    init_x = ix; init_y = iy; seed_x = sx; seed_y = sy; start = 1'b1;
    fit_valid = 1'b0;
    c0 = cyc;
    @(negedge clk);
    start = 1'b0;
    check_val("seed_load", lfsr_load, 1);
    check_val("seed_busy", busy, 1);
    check_val("seed_vals", {lfsr_seed_x, lfsr_seed_y}, {sx, sy});
    @(negedge clk);
    check_val("load_once", lfsr_load, 0);
    px = s16(ix); py = s16(iy); bfit = 32767; bx = 0; by = 0;
    for (int it = 0; it < N_IT; it++) begin
      wait_cand(1'b0, ok);
      if (!ok) return;
      dx = ext9(samp_x); dy = ext9(samp_y);
      ox = dx >>> DSH; oy = dy >>> DSH;
      sh = S0 + (it >> DL);
      if (sh > 15) sh = 15;
      cxl = 16'(sat(px + ox)); cyl = 16'(sat(py + oy));
      cxr = 16'(sat(px - ox)); cyr = 16'(sat(py - oy));
      case (fmode)
        0: begin fl = 5; fr = 10; end
        1: begin fl = 7; fr = 7; end
        2: begin fl = s16(16'($urandom)); fr = s16(16'($urandom)); end
        3: begin fl = 0; fr = 0; end
        default: begin fl = 10; fr = 5; end
      endcase
      npx = px; npy = py;
      if (fl < fr) begin npx = sat(px + (dx >>> sh)); npy = sat(py + (dy >>> sh)); end
      else if (fl > fr) begin npx = sat(px - (dx >>> sh)); npy = sat(py - (dy >>> sh)); end
      sb.push_back('{"cand_l", cxl, cyl});
      sb.push_back('{"cand_r", cxr, cyr});
      sb.push_back('{"pos", 16'(npx), 16'(npy)});

      // Left antenna
      for (int w = 0; w < waitc; w++) begin
        fit_valid = 1'b0; fit_value = 16'h8000;
        check_val("hold_l", {cand_x, cand_y}, {sb[0].x, sb[0].y});
        @(negedge clk);
      end
      e = sb.pop_front();
      check_val({e.tag, "_xy"}, {cand_x, cand_y}, {e.x, e.y});
      check_val("side_l", {cand_valid, cand_side}, 2'b10);
      if (it == pulse_it) begin start = 1'b1; init_x = 16'h1234; end
      fit_valid = 1'b1; fit_value = 16'(fl);
      if (fl < bfit) begin bfit = fl; bx = s16(cxl); by = s16(cyl); end
      @(negedge clk);
      start = 1'b0;

      // Right antenna
      wait_cand(1'b1, ok);
      if (!ok) return;
      for (int w = 0; w < waitc; w++) begin
        fit_valid = 1'b0; fit_value = 16'h8000;
        check_val("hold_r", {cand_x, cand_y}, {sb[0].x, sb[0].y});
        @(negedge clk);
      end
      e = sb.pop_front();
      check_val({e.tag, "_xy"}, {cand_x, cand_y}, {e.x, e.y});
      check_val("side_r", {cand_valid, cand_side}, 2'b11);
      if (it == abort_it) begin
        rst_n = 1'b0;
        #1;
        chk_zero("abort");
        $display("[TB] abort at iter %0d", it);
        return;
      end
      fit_valid = 1'b1; fit_value = 16'(fr);
      if (fr < bfit) begin bfit = fr; bx = s16(cxr); by = s16(cyr); end
      @(negedge clk);
      fit_valid = (waitc == 0);
      check_val("cv_update", cand_valid, 0);
      @(negedge clk);
      e = sb.pop_front();
      check_val({e.tag, "_xy"}, {pos_x, pos_y}, {e.x, e.y});
      check_val("iter", iter, 32'(it + 1));
      check_val("done_flag", done, (it == N_IT - 1) ? 1 : 0);
      $display("[TB] it=%0d dir=(%0d,%0d) fl=%0d fr=%0d pos=(%04h,%04h)",
               it, dx, dy, fl, fr, pos_x, pos_y);
      px = npx; py = npy;
    end
    check_val("done_cycle", cyc - c0, 4 * N_IT + 2 + 2 * waitc * N_IT);
    @(negedge clk);
    fit_valid = 1'b0;
    check_val("idle_busy_done", {busy, done}, 2'b00);
    check_val("pos_hold", {pos_x, pos_y}, {16'(px), 16'(py)});
    check_val("iter_hold", iter, N_IT);
`ifdef BAS_BEST_TRACK_EN
    check_val("best_fit", best_fit, 16'(bfit));
    check_val("best_xy", {best_x, best_y}, {16'(bx), 16'(by)});
`else
    check_val("best_fit", best_fit, 16'h7FFF);
    check_val("best_xy", {best_x, best_y}, {16'(px), 16'(py)});
`endif
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    run(16'h0100, 16'h0100, 9'h040, 9'h1C0, 0, 0, -1, -1);
    run(16'h0100, 16'h0100, 9'h040, 9'h1C0, 1, 0, -1, -1);
    run(16'h7FF0, 16'h8010, 9'h0FF, 9'h101, 2, 0, -1, 5);
    run(16'h0100, 16'hFF00, 9'h000, 9'h000, 3, 0, -1, -1);
    run(16'hF000, 16'h0C00, 9'h155, 9'h0AA, 2, 3, -1, -1);
    run(16'h0200, 16'h0300, 9'h1F3, 9'h027, 0, 0, 3, -1);
    @(negedge clk);
    rst_n = 1'b1;
    run(16'h0200, 16'h0300, 9'h1F3, 9'h027, 4, 0, -1, -1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/bas_search_ctrl.md
# bas_search_ctrl

- Iteration controller for fixed-point Beetle Antennae Search (BAS); sits directly downstream of the 9-bit direction LFSR.
- Seeds the LFSR, samples one random direction per iteration, and forms left/right antenna candidates.
- Obtains two fitness values through a handshake with an external evaluator and moves the beetle toward the lower-fitness antenna with a decaying step.

## Interface
- N_ITER, 64, iterations per run (1..65535)
- D_SHIFT, 2, antenna length = 2^-D_SHIFT × direction
- STEP_SHIFT0, 1, initial step shift
- DECAY_LOG2, 3, step shift increments every 2^DECAY_LOG2 iterations
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  begin run; sampled only in IDLE
- init_x, init_y  in  16  signed Q8.8 start position
- seed_x, seed_y  in  9  LFSR seeds
- lfsr_load  out  1  load strobe to LFSR
- lfsr_seed_x, lfsr_seed_y  out  9  seeds driven to LFSR
- dir_x, dir_y  in  9  LFSR outputs, read as signed Q1.8
- cand_x, cand_y  out  16  candidate position, signed Q8.8
- cand_valid  out  1  candidate awaiting fitness
- cand_side  out  1  0 = left antenna, 1 = right antenna
- fit_valid  in  1  fit_value valid for the current candidate
- fit_value  in  16  signed fitness (lower is better)
- pos_x, pos_y  out  16  current position
- iter  out  16  completed iterations
- busy  out  1  high outside IDLE
- done  out  1  one-cycle pulse at end of run
- best_x, best_y, best_fit  out  16  best candidate and its fitness

## Operation
- States: IDLE, SEED, SAMPLE, EVAL_L, EVAL_R, UPDATE, DONE.
- IDLE:
  - On start=1, latch init_x/init_y into pos, latch seeds, clear iter, set best_fit=16'sh7FFF, go to SEED.
  - start is ignored in all other states.
- SEED: lfsr_load=1 for exactly one cycle; lfsr_seed_* = latched seeds; go to SAMPLE.
- SAMPLE: capture dir_x/dir_y into internal direction registers.
  - The first SAMPLE captures the seeds; later SAMPLEs capture the free-running LFSR value.
  - Go to EVAL_L.
- Offset computation:
  - Sign-extend each direction component to 16 bits.
  - off = ext >>> D_SHIFT (arithmetic).
  - step = ext >>> sh, where sh = min(15, STEP_SHIFT0 + (iter >> DECAY_LOG2)).
- EVAL_L: cand = pos + off, cand_side=0, cand_valid=1. On fit_valid, latch f_l and go to EVAL_R.
- EVAL_R: cand = pos − off, cand_side=1, cand_valid=1. On fit_valid, latch f_r and go to UPDATE.
- fit_valid is ignored while cand_valid=0.
- UPDATE (one cycle):
  - If f_l < f_r: pos += step.
  - If f_l > f_r: pos −= step.
  - If equal: pos unchanged.
  - Increment iter. If iter == N_ITER, go to DONE; otherwise go to SAMPLE.
- DONE: done=1 for one cycle, then go to IDLE. pos, iter and best_* hold until the next start.
- Arithmetic rules:
  - All adds and subtracts saturate to [−32768, 32767].
  - Fitness comparisons are signed.
- A zero direction (for example seed 0) is legal: candidates equal pos and pos never moves.

## Timing
- All outputs reset to 0 (best_fit included) and the state resets to IDLE.
- Reset assertion mid-run aborts immediately and asynchronously; no done pulse is produced.
- cand_valid is registered: it rises on entering EVAL_L and stays high through EVAL_R.
  - cand_x/cand_y/cand_side change on the EVAL_L→EVAL_R edge.
  - cand_valid falls on entering UPDATE.
- Cycle count, with start sampled in cycle 0 and fit_valid tied high:
  - SEED is cycle 1.
  - Each iteration takes 4 cycles.
  - done is high in cycle 4·N_ITER+2.
- Each evaluator wait cycle adds one cycle to the iteration.

## Configuration
- Macro: BAS_BEST_TRACK_EN.
- Defined:
  - On each latched fitness, if fit_value < best_fit (strict), load best_fit and best_x/best_y from that candidate.
  - Ties keep the earlier candidate.
- Undefined:
  - best_x/best_y mirror pos_x/pos_y.
  - best_fit is constant 16'sh7FFF after the first start (0 from reset).
  - No comparator or best registers are built.

## Test plan
- Reset: drive reset=0 mid-EVAL_R → all outputs 0, busy=0, and the next start runs normally.
- Candidates: init (0x0100, 0x0100), seed_x=0x040, seed_y=0x1C0, D_SHIFT=2:
  - Left candidate = (0x0110, 0x00F0); right candidate = (0x00F0, 0x0110).
  - lfsr_load is high for one cycle only.
- Move:
  - Same setup with f_l=5, f_r=10, STEP_SHIFT0=1 → pos = (0x0120, 0x00E0), iter=1.
  - f_l=f_r=7 → pos unchanged.
- Saturation: init_x=0x7FF0, seed_x=0x0FF → left cand_x = 0x7FFF, right cand_x = 0x7FB1.
- Run length: seeds 0, N_ITER=64, fit_valid tied 1:
  - done in cycle 258, pos = init.
  - With BAS_BEST_TRACK_EN and fitness 0 every time: best_fit = 0, best_x/best_y = first left candidate.
- Wait states and decay:
  - fit_valid delayed 3 cycles per evaluation → cand_* hold stable throughout the wait.
  - sh steps from STEP_SHIFT0 to STEP_SHIFT0+1 at iter=8 (DECAY_LOG2=3).
